// File: rtl/fir_coef_ctrl_if.sv
// Upstream sample handshake and host coefficient-configuration bus for fir_coef_ctrl.
interface fir_coef_ctrl_if #(
   parameter int unsigned NTAPS = 11,
   parameter int unsigned DW    = 16,
   parameter int unsigned AW    = $clog2(NTAPS)
) ();

   // Sample stream
   logic          sample_valid_i;
   logic [DW-1:0] sample_i;
   logic          sample_ready_o;

   // Coefficient configuration
   logic          cfg_wr_i;
   logic [AW-1:0] cfg_addr_i;
   logic [DW-1:0] cfg_data_i;
   logic          cfg_commit_i;
   logic          cfg_busy_o;
   logic          cfg_err_o;

   // Upstream source and host side
   modport master (
      output sample_valid_i, sample_i, cfg_wr_i, cfg_addr_i, cfg_data_i, cfg_commit_i,
      input  sample_ready_o, cfg_busy_o, cfg_err_o
   );

   // Controller side
   modport slave (
      input  sample_valid_i, sample_i, cfg_wr_i, cfg_addr_i, cfg_data_i, cfg_commit_i,
      output sample_ready_o, cfg_busy_o, cfg_err_o
   );

endinterface

// File: rtl/fir_coef_ctrl.sv
// Sequencing and coefficient-bank controller in front of a pipelined FIR filter.
// Shadow bank is host-written; a commit copies it into the active bank in a one-cycle
// SWAP state, after which out_valid_o is held off until the pipeline has flushed.
module fir_coef_ctrl #(
   parameter int unsigned NTAPS    = 11,
   parameter int unsigned DW       = 16,
   parameter int unsigned PIPE_LAT = 6,
   parameter int unsigned AW       = $clog2(NTAPS)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   fir_coef_ctrl_if.slave      ctrl_bus,
   output logic                strobe_o,
   output logic [DW-1:0]       data_o,
   output logic [NTAPS*DW-1:0] coef_o,
   output logic                out_valid_o
);

   localparam int unsigned WarmInit = NTAPS - 1 + PIPE_LAT;
   localparam int unsigned WCW      = $clog2(WarmInit + 1);

   typedef enum logic [1:0] {StRun, StSwap, StWarm} state_e;

   state_e                     state_q, state_d;
   logic [WCW-1:0]             warm_q, warm_d;
   logic                       strobe_q;
   logic [DW-1:0]              data_q, data_d;
   logic                       out_valid_q, out_valid_d;
   logic                       cfg_err_q, cfg_err_d;
   logic [NTAPS-1:0][DW-1:0]   shadow_q, shadow_d;
   logic [NTAPS-1:0][DW-1:0]   active_q, active_d;
   logic                       accept;
   logic                       wr_en;
   logic                       addr_ok;

   assign ctrl_bus.sample_ready_o = (state_q != StSwap);
   assign ctrl_bus.cfg_busy_o     = (state_q == StSwap);
   assign ctrl_bus.cfg_err_o      = cfg_err_q;

   assign accept  = ctrl_bus.sample_valid_i & ctrl_bus.sample_ready_o;
   assign wr_en   = ctrl_bus.cfg_wr_i & (state_q != StSwap);
   assign addr_ok = 32'(ctrl_bus.cfg_addr_i) < NTAPS;

   // Next state and warm-up counter; a commit in WARM restarts the flush from scratch
   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      unique case (state_q)
         StRun: begin
            if (ctrl_bus.cfg_commit_i) state_d = StSwap;
         end
         StSwap: begin
            warm_d  = WCW'(PIPE_LAT);
            state_d = StWarm;
         end
         StWarm: begin
            if (strobe_q && (warm_q != '0)) warm_d = warm_q - 1'b1;
            if (ctrl_bus.cfg_commit_i) state_d = StSwap;
            else if (warm_d == '0)     state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   // Datapath next-state: sample capture, bank updates, sticky error, result-valid tracking
   always_comb begin
      data_d      = accept ? ctrl_bus.sample_i : data_q;
      shadow_d    = shadow_q;
      active_d    = (state_q == StSwap) ? shadow_q : active_q;
      cfg_err_d   = cfg_err_q;
      if (wr_en) begin
         if (addr_ok) shadow_d[ctrl_bus.cfg_addr_i] = ctrl_bus.cfg_data_i;
         else         cfg_err_d = 1'b1;
      end
      // The strobe that retires the last warm-up count is the first one with clean taps
      out_valid_d = strobe_q & ((state_q == StRun) |
                                ((state_q == StWarm) & (warm_q == WCW'(1))));
   end

   // State registers; reset lands in WARM so the first delay-line fill is flushed
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StWarm;
         warm_q      <= WCW'(WarmInit);
         strobe_q    <= 1'b0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         shadow_q    <= '0;
         active_q    <= '0;
      end else begin
         state_q     <= state_d;
         warm_q      <= warm_d;
         strobe_q    <= accept;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         cfg_err_q   <= cfg_err_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
      end
   end

   assign strobe_o    = strobe_q;
   assign data_o      = data_q;
   assign out_valid_o = out_valid_q;
   assign coef_o      = active_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: streaming, bank swap, warm-up and reset scenarios.
module tb_fir_coef_ctrl;

   localparam int unsigned NTAPS = 11;
   localparam int unsigned DW    = 16;

   logic                clk = 1'b0;
   logic                rst_ni = 1'b0;
   logic                strobe;
   logic [DW-1:0]       data;
   logic [NTAPS*DW-1:0] coef;
   logic                out_valid;
   int                  checks = 0;
   int                  errors = 0;

   fir_coef_ctrl_if #(.NTAPS(NTAPS), .DW(DW)) bus_if ();

   fir_coef_ctrl #(.NTAPS(NTAPS), .DW(DW), .PIPE_LAT(6)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .ctrl_bus   (bus_if),
      .strobe_o   (strobe),
      .data_o     (data),
      .coef_o     (coef),
      .out_valid_o(out_valid)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (strobe !== 1'b0 || data !== 16'h0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: strobe=%b data=%h out_valid=%b, want 0 0000 0",
                  strobe, data, out_valid);
      end
      checks++;
      if (coef !== '0 || bus_if.cfg_err_o !== 1'b0 || bus_if.cfg_busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_cfg: coef=%h err=%b busy=%b, want 0 0 0",
                  coef, bus_if.cfg_err_o, bus_if.cfg_busy_o);
      end
      checks++;
      if (bus_if.sample_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", bus_if.sample_ready_o);
      end
      @(negedge clk) rst_ni = 1'b1;
   endtask

   // 20 back-to-back samples: first result flagged is from strobe 16, seen during strobe 17
   task automatic test_stream();
      logic [15:0] v;
      for (int k = 1; k <= 20; k++) begin
         v = 16'h1000 + 16'(k);
         bus_if.sample_valid_i = 1'b1;
         bus_if.sample_i       = v;
         step();
         checks++;
         if (strobe !== 1'b1 || data !== v) begin
            errors++;
            $display("FAIL stream_strobe[%0d]: strobe=%b data=%h, want 1 %h", k, strobe, data, v);
         end
         checks++;
         if (out_valid !== (k >= 17)) begin
            errors++;
            $display("FAIL stream_out_valid[%0d]: got %b want %b", k, out_valid, (k >= 17));
         end
      end
      bus_if.sample_valid_i = 1'b0;
      step();
      checks++;
      if (strobe !== 1'b0 || data !== 16'h1014 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stream_tail: strobe=%b data=%h ov=%b, want 0 1014 1",
                  strobe, data, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_idle_ov: got %b want 0", out_valid);
      end
   endtask

   task automatic test_cfg_write();
      logic [NTAPS*DW-1:0] exp;
      for (int i = 0; i < 11; i++) begin
         bus_if.cfg_wr_i   = 1'b1;
         bus_if.cfg_addr_i = 4'(i);
         bus_if.cfg_data_i = 16'(i + 1);
         exp[i*16 +: 16]   = 16'(i + 1);
         step();
      end
      bus_if.cfg_addr_i = 4'd12;
      bus_if.cfg_data_i = 16'hDEAD;
      step();
      bus_if.cfg_wr_i = 1'b0;
      checks++;
      if (coef !== '0) begin
         errors++;
         $display("FAIL cfg_shadow_hidden: coef=%h want 0", coef);
      end
      checks++;
      if (bus_if.cfg_err_o !== 1'b1) begin
         errors++;
         $display("FAIL cfg_err_set: got %b want 1", bus_if.cfg_err_o);
      end
      bus_if.cfg_commit_i = 1'b1;
      step();
      bus_if.cfg_commit_i = 1'b0;
      checks++;
      if (bus_if.cfg_busy_o !== 1'b1 || bus_if.sample_ready_o !== 1'b0 || coef !== '0) begin
         errors++;
         $display("FAIL cfg_swap_cycle: busy=%b ready=%b coef=%h, want 1 0 0",
                  bus_if.cfg_busy_o, bus_if.sample_ready_o, coef);
      end
      step();
      checks++;
      if (bus_if.cfg_busy_o !== 1'b0 || coef !== exp) begin
         errors++;
         $display("FAIL cfg_swapped: busy=%b coef=%h, want 0 %h", bus_if.cfg_busy_o, coef, exp);
      end
      step();
      checks++;
      if (bus_if.cfg_busy_o !== 1'b0 || bus_if.cfg_err_o !== 1'b1) begin
         errors++;
         $display("FAIL cfg_after: busy=%b err=%b, want 0 1", bus_if.cfg_busy_o, bus_if.cfg_err_o);
      end
      // Finish the 6-strobe warm-up so the next scenario starts in RUN
      for (int k = 1; k <= 6; k++) begin
         bus_if.sample_valid_i = 1'b1;
         bus_if.sample_i       = 16'h2000 + 16'(k);
         step();
      end
      bus_if.sample_valid_i = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL cfg_warm_done: out_valid=%b want 1", out_valid);
      end
      step();
   endtask

   // Commit at cycle 3 alongside an accepted sample; cycle 4's offer is stalled
   task automatic test_commit_run();
      logic [15:0] v;
      logic [15:0] exp_data;
      logic        exp_strobe, exp_ov, exp_ready;
      for (int c = 1; c <= 13; c++) begin
         v = (c <= 4) ? 16'h3000 + 16'(c) : 16'h3000 + 16'(c - 1);
         bus_if.sample_valid_i = 1'b1;
         bus_if.sample_i       = v;
         bus_if.cfg_commit_i   = (c == 3);
         step();
         exp_strobe = (c != 4);
         exp_data   = (c == 4) ? 16'h3003 : v;
         exp_ov     = (c == 2) || (c == 3) || (c >= 11);
         exp_ready  = (c != 3);
         checks++;
         if (strobe !== exp_strobe || data !== exp_data) begin
            errors++;
            $display("FAIL commit_strobe[%0d]: strobe=%b data=%h, want %b %h",
                     c, strobe, data, exp_strobe, exp_data);
         end
         checks++;
         if (out_valid !== exp_ov || bus_if.sample_ready_o !== exp_ready) begin
            errors++;
            $display("FAIL commit_ov_ready[%0d]: ov=%b ready=%b, want %b %b",
                     c, out_valid, bus_if.sample_ready_o, exp_ov, exp_ready);
         end
      end
      bus_if.cfg_commit_i   = 1'b0;
      bus_if.sample_valid_i = 1'b0;
      step();
      step();
   endtask

   task automatic test_write_commit();
      bus_if.cfg_wr_i     = 1'b1;
      bus_if.cfg_addr_i   = 4'd3;
      bus_if.cfg_data_i   = 16'h00AA;
      bus_if.cfg_commit_i = 1'b1;
      step();
      bus_if.cfg_commit_i = 1'b0;
      bus_if.cfg_addr_i   = 4'd5;
      bus_if.cfg_data_i   = 16'h5555;
      checks++;
      if (bus_if.cfg_busy_o !== 1'b1 || coef[3*16 +: 16] !== 16'd4) begin
         errors++;
         $display("FAIL wc_swap: busy=%b tap3=%h, want 1 0004",
                  bus_if.cfg_busy_o, coef[3*16 +: 16]);
      end
      step();
      bus_if.cfg_wr_i = 1'b0;
      checks++;
      if (coef[3*16 +: 16] !== 16'h00AA || coef[5*16 +: 16] !== 16'd6) begin
         errors++;
         $display("FAIL wc_taps: tap3=%h tap5=%h, want 00aa 0006",
                  coef[3*16 +: 16], coef[5*16 +: 16]);
      end
      bus_if.cfg_commit_i = 1'b1;
      step();
      bus_if.cfg_commit_i = 1'b0;
      step();
      checks++;
      if (coef[5*16 +: 16] !== 16'd6 || coef[3*16 +: 16] !== 16'h00AA) begin
         errors++;
         $display("FAIL wc_swap_write_dropped: tap5=%h tap3=%h, want 0006 00aa",
                  coef[5*16 +: 16], coef[3*16 +: 16]);
      end
   endtask

   // Enters in WARM with count 6; three strobes leave 3, then a commit must reload to 6
   task automatic test_warm_recommit();
      for (int k = 1; k <= 3; k++) begin
         bus_if.sample_valid_i = 1'b1;
         bus_if.sample_i       = 16'h4000 + 16'(k);
         step();
      end
      bus_if.sample_valid_i = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL warm_partial_ov: got %b want 0", out_valid);
      end
      bus_if.cfg_commit_i = 1'b1;
      step();
      bus_if.cfg_commit_i = 1'b0;
      checks++;
      if (bus_if.cfg_busy_o !== 1'b1) begin
         errors++;
         $display("FAIL warm_recommit_busy: got %b want 1", bus_if.cfg_busy_o);
      end
      step();
      for (int k = 1; k <= 7; k++) begin
         bus_if.sample_valid_i = 1'b1;
         bus_if.sample_i       = 16'h4100 + 16'(k);
         step();
         checks++;
         if (out_valid !== (k >= 7)) begin
            errors++;
            $display("FAIL warm_reload_ov[%0d]: got %b want %b", k, out_valid, (k >= 7));
         end
      end
      bus_if.sample_valid_i = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL warm_reload_run: got %b want 1", out_valid);
      end
      step();
   endtask

   task automatic test_async_reset();
      bus_if.cfg_wr_i   = 1'b1;
      bus_if.cfg_addr_i = 4'd0;
      bus_if.cfg_data_i = 16'h1234;
      step();
      bus_if.cfg_wr_i     = 1'b0;
      bus_if.cfg_commit_i = 1'b1;
      step();
      bus_if.cfg_commit_i = 1'b0;
      step();
      for (int k = 1; k <= 2; k++) begin
         bus_if.sample_valid_i = 1'b1;
         bus_if.sample_i       = 16'h5000 + 16'(k);
         step();
      end
      bus_if.sample_valid_i = 1'b0;
      checks++;
      if (strobe !== 1'b1 || coef[15:0] !== 16'h1234) begin
         errors++;
         $display("FAIL rst_pre: strobe=%b tap0=%h, want 1 1234", strobe, coef[15:0]);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (strobe !== 1'b0 || data !== 16'h0 || out_valid !== 1'b0 || coef !== '0 ||
          bus_if.cfg_err_o !== 1'b0 || bus_if.cfg_busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: strobe=%b data=%h ov=%b coef=%h err=%b busy=%b, want all 0",
                  strobe, data, out_valid, coef, bus_if.cfg_err_o, bus_if.cfg_busy_o);
      end
      @(negedge clk) rst_ni = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         bus_if.sample_valid_i = 1'b1;
         bus_if.sample_i       = 16'h6000 + 16'(k);
         step();
         checks++;
         if (out_valid !== (k >= 17)) begin
            errors++;
            $display("FAIL rst_warmup_ov[%0d]: got %b want %b", k, out_valid, (k >= 17));
         end
      end
      bus_if.sample_valid_i = 1'b0;
      step();
      bus_if.cfg_commit_i = 1'b1;
      step();
      bus_if.cfg_commit_i = 1'b0;
      step();
      checks++;
      if (coef !== '0) begin
         errors++;
         $display("FAIL rst_shadow_cleared: coef=%h want 0", coef);
      end
   endtask

   initial begin
      bus_if.sample_valid_i = 1'b0;
      bus_if.sample_i       = '0;
      bus_if.cfg_wr_i       = 1'b0;
      bus_if.cfg_addr_i     = '0;
      bus_if.cfg_data_i     = '0;
      bus_if.cfg_commit_i   = 1'b0;
      test_reset();
      test_stream();
      test_cfg_write();
      test_commit_run();
      test_write_commit();
      test_warm_recommit();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
